// File: rtl/binary_to_bcd_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | binary_to_bcd_seq_if                                                 |
// | Start/busy/done handshake and result bus of the BCD converter.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface binary_to_bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  en;
  logic                  start;
  logic                  signed_mode;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  sign;
  logic                  overflow;

  modport master (
    output en, start, signed_mode, bin_in,
    input  busy, done, bcd_out, sign, overflow
  );

  modport slave (
    input  en, start, signed_mode, bin_in,
    output busy, done, bcd_out, sign, overflow
  );
endinterface
`default_nettype wire

// File: rtl/binary_to_bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | binary_to_bcd_seq                                                    |
// | Sequential double-dabble binary-to-BCD converter, one shift per      |
// | enabled clock, with signed mode and overflow flag.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module binary_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  binary_to_bcd_seq_if.slave  bus
);

  localparam int c_bcd_w = 4 * DIGITS;
  localparam int c_cnt_w = $clog2(BIN_W + 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]     mag_q, mag_d;
  logic [c_bcd_w-1:0]   scr_q, scr_d;
  logic                 psign_q, psign_d;
  logic                 povf_q, povf_d;
  logic [c_bcd_w-1:0]   bcd_q, bcd_d;
  logic                 sign_q, sign_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic [c_bcd_w-1:0]   w_adj;
  logic [c_bcd_w-1:0]   w_scr_shift;
  logic                 w_carry_out;
  logic                 w_neg_in;

  // Per-digit add-3 correction ahead of the shift; digits never carry into each other.
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    assign w_adj[4*k +: 4] = (scr_q[4*k +: 4] >= 4'd5) ? (scr_q[4*k +: 4] + 4'd3)
                                                        : scr_q[4*k +: 4];
  end

  assign w_scr_shift = {w_adj[c_bcd_w-2:0], mag_q[BIN_W-1]};
  assign w_carry_out = w_adj[c_bcd_w-1];
  assign w_neg_in    = bus.signed_mode & bus.bin_in[BIN_W-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    psign_d = psign_q;
    povf_d  = povf_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    if (bus.en) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_SHIFT;
            mag_d   = w_neg_in ? ((~bus.bin_in) + BIN_W'(1)) : bus.bin_in;
            psign_d = w_neg_in;
            scr_d   = '0;
            cnt_d   = '0;
            povf_d  = 1'b0;
          end
        end
        S_SHIFT: begin
          scr_d  = w_scr_shift;
          mag_d  = {mag_q[BIN_W-2:0], 1'b0};
          povf_d = povf_q | w_carry_out;
          cnt_d  = cnt_q + c_cnt_w'(1);
          // Final shift publishes the result on the same edge.
          if (cnt_q == c_cnt_w'(BIN_W - 1)) begin
            state_d = S_IDLE;
            bcd_d   = w_scr_shift;
            sign_d  = psign_q;
            ovf_d   = povf_q | w_carry_out;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      scr_q   <= '0;
      psign_q <= 1'b0;
      povf_q  <= 1'b0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      psign_q <= psign_d;
      povf_q  <= povf_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = (state_q == S_SHIFT);
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.sign     = sign_q;
  assign bus.overflow = ovf_q;

endmodule
`default_nettype wire
